// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port, memory bus and stall for the unified memory arbiter.
interface mem_arbiter_if;
  // Instruction-fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  // MEM-stage data port
  logic        d_req;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  // Single-port memory
  logic        mem_en;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  // Pipeline stall
  logic        stall;

  // Pipeline and memory side: drives requests and read data, observes the arbiter
  modport master (
    output if_req, if_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_wen, mem_addr, mem_wdata, stall
  );

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_wen, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the data port.
// One access at a time: IDLE grants, BUSY waits MEM_LATENCY cycles, DONE pulses ready.
// Data has priority; after STARVE_LIMIT data wins over a waiting fetch, fetch goes first.
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] LatCnt    = 4'(MEM_LATENCY);
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  r_starve;
  logic        r_owner_d;   // 1: data port owns the current access
  logic        r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic        w_any_req;
  logic        w_grant_d;
  logic        w_last;
  logic        w_if_ready;
  logic        w_d_ready;

  // Arbitration decision and end-of-latency detect
  always_comb begin
    w_any_req = bus.if_req | bus.d_req;
    w_grant_d = bus.d_req & (~bus.if_req | (r_starve != StarveMax));
    w_last    = (r_cnt == LatCnt);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_any_req) w_state_next = StBusy;
      StBusy: if (w_last) w_state_next = StDone;
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Access datapath: latch payload at grant, count latency, capture read data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_starve   <= '0;
      r_owner_d  <= 1'b0;
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_cnt     <= 4'd1;
            r_owner_d <= w_grant_d;
            r_wen     <= w_grant_d & bus.d_wen;
            r_addr    <= w_grant_d ? bus.d_addr : bus.if_addr;
            r_wdata   <= w_grant_d ? bus.d_wdata : '0;
            if (w_grant_d) begin
              // Count data wins only while fetch is actually waiting
              if (bus.if_req && (r_starve != StarveMax)) r_starve <= r_starve + 4'd1;
            end else begin
              r_starve <= '0;
            end
          end
        end
        StBusy: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_last && !r_wen) begin
            if (r_owner_d) r_d_rdata <= bus.mem_rdata;
            else           r_if_rdata <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: strobe only in the first BUSY cycle, ready only in DONE
  always_comb begin
    w_if_ready    = (r_state == StDone) & ~r_owner_d;
    w_d_ready     = (r_state == StDone) & r_owner_d;
    bus.mem_en    = (r_state == StBusy) & (r_cnt == 4'd1);
    bus.mem_wen   = (r_state == StBusy) & (r_cnt == 4'd1) & r_wen;
    bus.mem_addr  = r_addr;
    bus.mem_wdata = r_wdata;
    bus.if_ready  = w_if_ready;
    bus.d_ready   = w_d_ready;
    bus.if_rdata  = r_if_rdata;
    bus.d_rdata   = r_d_rdata;
    bus.stall     = (bus.if_req & ~w_if_ready) | (bus.d_req & ~w_d_ready);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 (latency 2, starve limit 2) and
// instance 1 (latency 1, starve limit 0) share clock and reset.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          inst;
    int          cyc;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    int          inst;
    int          cyc;
    logic [31:0] data;
  } rsp_t;

  typedef struct packed {
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
  } outs_t;

  acc_t exp_acc[$];
  rsp_t exp_if[$];
  rsp_t exp_d[$];

  logic        s_if_req  [2];
  logic [31:0] s_if_addr [2];
  logic        s_d_req   [2];
  logic        s_d_wen   [2];
  logic [31:0] s_d_addr  [2];
  logic [31:0] s_d_wdata [2];

  mem_arbiter_if bus_a ();
  mem_arbiter_if bus_b ();

  mem_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(2)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(0)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Memory contents model: a few fixed words, everything else a hash of the address
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'hDEAD_BEEF;
      32'h0000_0000: return 32'h0000_0013;
      default:       return a ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  assign bus_a.if_req    = s_if_req[0];
  assign bus_a.if_addr   = s_if_addr[0];
  assign bus_a.d_req     = s_d_req[0];
  assign bus_a.d_wen     = s_d_wen[0];
  assign bus_a.d_addr    = s_d_addr[0];
  assign bus_a.d_wdata   = s_d_wdata[0];
  assign bus_a.mem_rdata = mem_val(bus_a.mem_addr);

  assign bus_b.if_req    = s_if_req[1];
  assign bus_b.if_addr   = s_if_addr[1];
  assign bus_b.d_req     = s_d_req[1];
  assign bus_b.d_wen     = s_d_wen[1];
  assign bus_b.d_addr    = s_d_addr[1];
  assign bus_b.d_wdata   = s_d_wdata[1];
  assign bus_b.mem_rdata = mem_val(bus_b.mem_addr);

  function automatic int lat(input int inst);
    return (inst == 0) ? 2 : 1;
  endfunction

  function automatic outs_t get_outs(input int inst);
    outs_t o;
    if (inst == 0) begin
      o = '{bus_a.if_ready, bus_a.if_rdata, bus_a.d_ready, bus_a.d_rdata, bus_a.mem_en,
            bus_a.mem_wen, bus_a.mem_addr, bus_a.mem_wdata, bus_a.stall};
    end else begin
      o = '{bus_b.if_ready, bus_b.if_rdata, bus_b.d_ready, bus_b.d_rdata, bus_b.mem_en,
            bus_b.mem_wen, bus_b.mem_addr, bus_b.mem_wdata, bus_b.stall};
    end
    return o;
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc%0d: got 0x%08h want 0x%08h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input int inst);
    n_cmp++;
    n_bad++;
    $display("FAIL %s inst%0d cyc%0d: event seen, none expected", name, inst, cyc);
  endtask

  // Monitor: pop and compare whenever the DUT strobes memory or pulses ready
  task automatic mon(input int inst);
    outs_t o;
    int    idx;
    o = get_outs(inst);
    if (o.mem_en === 1'b1) begin
      idx = -1;
      foreach (exp_acc[i]) if (idx < 0 && exp_acc[i].inst == inst) idx = i;
      if (idx < 0) fail_evt("mem_en", inst);
      else begin
        chk("mem_en_cycle", inst, 32'(cyc), 32'(exp_acc[idx].cyc));
        chk("mem_addr", inst, o.mem_addr, exp_acc[idx].addr);
        chk("mem_wen", inst, {31'b0, o.mem_wen}, {31'b0, exp_acc[idx].wen});
        if (exp_acc[idx].wen) chk("mem_wdata", inst, o.mem_wdata, exp_acc[idx].wdata);
        exp_acc.delete(idx);
      end
    end else if (o.mem_wen === 1'b1) begin
      fail_evt("mem_wen_without_en", inst);
    end
    if (o.if_ready === 1'b1) begin
      idx = -1;
      foreach (exp_if[i]) if (idx < 0 && exp_if[i].inst == inst) idx = i;
      if (idx < 0) fail_evt("if_ready", inst);
      else begin
        chk("if_ready_cycle", inst, 32'(cyc), 32'(exp_if[idx].cyc));
        chk("if_rdata", inst, o.if_rdata, exp_if[idx].data);
        exp_if.delete(idx);
      end
    end
    if (o.d_ready === 1'b1) begin
      idx = -1;
      foreach (exp_d[i]) if (idx < 0 && exp_d[i].inst == inst) idx = i;
      if (idx < 0) fail_evt("d_ready", inst);
      else begin
        chk("d_ready_cycle", inst, 32'(cyc), 32'(exp_d[idx].cyc));
        chk("d_rdata", inst, o.d_rdata, exp_d[idx].data);
        exp_d.delete(idx);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic push_acc(input int inst, input int c, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata);
    acc_t a;
    a.inst = inst; a.cyc = c; a.wen = wen; a.addr = addr; a.wdata = wdata;
    exp_acc.push_back(a);
  endtask

  task automatic push_rsp(input int inst, input bit is_d, input int c, input logic [31:0] data);
    rsp_t r;
    r.inst = inst; r.cyc = c; r.data = data;
    if (is_d) exp_d.push_back(r);
    else      exp_if.push_back(r);
  endtask

  task automatic check_zero(input int inst, input string tag);
    outs_t o;
    o = get_outs(inst);
    chk({tag, "_if_ready"}, inst, {31'b0, o.if_ready}, 32'd0);
    chk({tag, "_d_ready"}, inst, {31'b0, o.d_ready}, 32'd0);
    chk({tag, "_if_rdata"}, inst, o.if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, inst, o.d_rdata, 32'd0);
    chk({tag, "_mem_en"}, inst, {31'b0, o.mem_en}, 32'd0);
    chk({tag, "_mem_wen"}, inst, {31'b0, o.mem_wen}, 32'd0);
    chk({tag, "_mem_addr"}, inst, o.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, inst, o.mem_wdata, 32'd0);
    chk({tag, "_stall"}, inst, {31'b0, o.stall}, 32'd0);
  endtask

  // One request on one port; payload is disturbed after grant to show it was latched
  task automatic xact(input int inst, input bit is_d, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input bit chk_stall);
    int    t;
    bit    done;
    outs_t o;
    @(posedge clk); #1;
    t = cyc;
    if (is_d) begin
      s_d_req[inst] = 1'b1; s_d_wen[inst] = wen; s_d_addr[inst] = addr; s_d_wdata[inst] = wdata;
    end else begin
      s_if_req[inst] = 1'b1; s_if_addr[inst] = addr;
    end
    push_acc(inst, t + 1, wen, addr, wdata);
    push_rsp(inst, is_d, t + lat(inst) + 1, exp_rd);
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      o = get_outs(inst);
      done = is_d ? (o.d_ready === 1'b1) : (o.if_ready === 1'b1);
      if (chk_stall) chk("stall", inst, {31'b0, o.stall}, {31'b0, !done});
      if (k == 1) begin
        if (is_d) begin
          s_d_addr[inst] = ~addr; s_d_wdata[inst] = ~wdata; s_d_wen[inst] = ~wen;
        end else begin
          s_if_addr[inst] = ~addr;
        end
      end
    end
    if (!done) fail_evt("ready_timeout", inst);
    s_if_req[inst] = 1'b0;
    s_d_req[inst]  = 1'b0;
  endtask

  // Both ports held high; order gives the expected owner of each successive access
  task automatic contend(input int inst, input logic [31:0] faddr, input logic [31:0] daddr,
                         input string order, input int drop_f_at);
    int    t0;
    int    per;
    int    seen;
    bit    is_d;
    byte   ch;
    outs_t o;
    @(posedge clk); #1;
    t0 = cyc;
    per = lat(inst) + 2;
    s_if_req[inst] = 1'b1; s_if_addr[inst] = faddr;
    s_d_req[inst]  = 1'b1; s_d_addr[inst]  = daddr; s_d_wen[inst] = 1'b0; s_d_wdata[inst] = '0;
    for (int k = 0; k < order.len(); k++) begin
      ch = order[k];
      is_d = (ch == "D");
      push_acc(inst, t0 + 1 + per * k, 1'b0, is_d ? daddr : faddr, 32'd0);
      push_rsp(inst, is_d, t0 + lat(inst) + 1 + per * k, mem_val(is_d ? daddr : faddr));
    end
    seen = 0;
    for (int c = 0; c < 200 && seen < order.len(); c++) begin
      @(negedge clk);
      o = get_outs(inst);
      if (o.if_ready === 1'b1 || o.d_ready === 1'b1) begin
        seen++;
        if (seen == drop_f_at) s_if_req[inst] = 1'b0;
      end
    end
    if (seen < order.len()) fail_evt("contend_timeout", inst);
    s_if_req[inst] = 1'b0;
    s_d_req[inst]  = 1'b0;
  endtask

  // Fetch aborted by reset in its second BUSY cycle: no ready, everything cleared
  task automatic reset_abort(input logic [31:0] addr);
    @(posedge clk); #1;
    s_if_req[0] = 1'b1; s_if_addr[0] = addr;
    push_acc(0, cyc + 1, 1'b0, addr, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    s_if_req[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_zero(0, "abort");
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_if_req[i] = 1'b0; s_if_addr[i] = '0;
      s_d_req[i] = 1'b0; s_d_wen[i] = 1'b0; s_d_addr[i] = '0; s_d_wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero(0, "rst");
    check_zero(1, "rst");

    // Single load, then a store that must leave d_rdata alone
    xact(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b1);
    xact(0, 1'b1, 1'b1, 32'h0000_0080, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1);
    // Starve limit 2: D, D, F, D, D, F
    contend(0, 32'h0000_0200, 32'h0000_0100, "DDFDDF", 6);

    // Latency 1 fetch, then starve limit 0: fetch always wins, data goes once fetch drops
    xact(1, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_0013, 1'b1);
    contend(1, 32'h0000_0400, 32'h0000_0300, "FFFD", 3);

    reset_abort(32'h0000_0080);
    xact(0, 1'b0, 1'b0, 32'h0000_0044, 32'h0, mem_val(32'h0000_0044), 1'b1);

    repeat (6) @(negedge clk);
    chk("acc_left", 0, 32'(exp_acc.size()), 32'd0);
    chk("if_left", 0, 32'(exp_if.size()), 32'd0);
    chk("d_left", 0, 32'(exp_d.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
